// File: rtl/tf_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : tf_stage_sched
// Brief    : Stage sequencer (seed write / read / drain) for the TF generator.
// Revision : 1.0  initial release
// ============================================================================
module tf_stage_sched #(
  parameter int DW         = 64,
  parameter int NUM_STAGES = 3,
  parameter int ITER       = 16,
  parameter int DEPTH      = 4,
  parameter int SEED_LEN   = 2,
  parameter int PIPE_LAT   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_modulus_in,
  input  logic          i_dp_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_TF_wen,
  output logic          o_TF_ren,
  output logic          o_LAST_STAGE,
  output logic [2:0]    o_l,
  output logic [2:0]    o_it_depth_cnt,
  output logic [DW-1:0] o_ite_sw_cnt,
  output logic [DW-1:0] o_ite_sw_cnt_ite3,
  output logic [DW-1:0] o_modulus
);

  localparam int              c_DRW        = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [2:0]      c_SEED_LAST  = 3'(SEED_LEN - 1);
  localparam logic [2:0]      c_DEPTH_LAST = 3'(DEPTH - 1);
  localparam logic [2:0]      c_L_LAST     = 3'(NUM_STAGES - 1);
  localparam logic [DW-1:0]   c_ITER_LAST  = DW'(ITER - 1);
  localparam logic [c_DRW-1:0] c_DRAIN_LAST = c_DRW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_wen;
  logic             r_ren_en;
  logic             r_last;
  logic [2:0]       r_l;
  logic [2:0]       r_depth;
  logic [DW-1:0]    r_ite;
  logic [DW-1:0]    r_ite3;
  logic [DW-1:0]    r_modulus;
  logic [c_DRW-1:0] r_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wen     <= 1'b0;
      r_ren_en  <= 1'b0;
      r_last    <= 1'b0;
      r_l       <= 3'd0;
      r_depth   <= 3'd0;
      r_ite     <= '0;
      r_ite3    <= '0;
      r_modulus <= '0;
      r_drain   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_SEED;
            r_busy    <= 1'b1;
            r_wen     <= 1'b1;
            r_ren_en  <= 1'b0;
            r_modulus <= i_modulus_in;
            r_l       <= 3'd0;
            r_last    <= (c_L_LAST == 3'd0);
            r_depth   <= 3'd0;
            r_ite     <= '0;
            r_ite3    <= '0;
          end
        end
        S_SEED: begin
          if (r_depth == c_SEED_LAST) begin
            r_state  <= S_RUN;
            r_wen    <= 1'b0;
            r_ren_en <= 1'b1;
            r_depth  <= 3'd0;
          end else begin
            r_depth <= r_depth + 3'd1;
          end
        end
        S_RUN: begin
          // Counters only advance on cycles where a read actually issues.
          if (i_dp_ready) begin
            if (r_depth == c_DEPTH_LAST) begin
              r_depth <= 3'd0;
              r_ite3  <= r_ite3 + DW'(1);
              if (r_ite == c_ITER_LAST) begin
                r_ite    <= '0;
                r_ren_en <= 1'b0;
                r_drain  <= '0;
                r_state  <= S_DRAIN;
              end else begin
                r_ite <= r_ite + DW'(1);
              end
            end else begin
              r_depth <= r_depth + 3'd1;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == c_DRAIN_LAST) begin
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_l     <= r_l + 3'd1;
              r_last  <= ((r_l + 3'd1) == c_L_LAST);
              r_wen   <= 1'b1;
              r_depth <= 3'd0;
              r_state <= S_SEED;
            end
          end else begin
            r_drain <= r_drain + c_DRW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read enable is the registered RUN qualifier gated by same-cycle readiness.
  assign o_TF_ren          = r_ren_en & i_dp_ready;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_TF_wen          = r_wen;
  assign o_LAST_STAGE      = r_last;
  assign o_l               = r_l;
  assign o_it_depth_cnt    = r_depth;
  assign o_ite_sw_cnt      = r_ite;
  assign o_ite_sw_cnt_ite3 = r_ite3;
  assign o_modulus         = r_modulus;

endmodule
`default_nettype wire

// File: tb/tb_tf_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tf_stage_sched
// Brief    : Self-checking bench for tf_stage_sched with a done scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_tf_stage_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_dp;
  logic [63:0] a_mod_in;
  logic        b_start, b_dp;
  logic [63:0] b_mod_in;

  logic        a_busy, a_done, a_wen, a_ren, a_last;
  logic [2:0]  a_l, a_dep;
  logic [63:0] a_ite, a_ite3, a_mod;
  logic        b_busy, b_done, b_wen, b_ren, b_last;
  logic [2:0]  b_l, b_dep;
  logic [63:0] b_ite, b_ite3, b_mod;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [63:0] ite3;
    logic [63:0] mod;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tf_stage_sched #(.DW(64), .NUM_STAGES(3), .ITER(4), .DEPTH(4), .SEED_LEN(2), .PIPE_LAT(3)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_modulus_in(a_mod_in), .i_dp_ready(a_dp),
    .o_busy(a_busy), .o_done(a_done), .o_TF_wen(a_wen), .o_TF_ren(a_ren), .o_LAST_STAGE(a_last),
    .o_l(a_l), .o_it_depth_cnt(a_dep), .o_ite_sw_cnt(a_ite), .o_ite_sw_cnt_ite3(a_ite3), .o_modulus(a_mod)
  );

  tf_stage_sched #(.DW(64), .NUM_STAGES(1), .ITER(1), .DEPTH(1), .SEED_LEN(1), .PIPE_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_modulus_in(b_mod_in), .i_dp_ready(b_dp),
    .o_busy(b_busy), .o_done(b_done), .o_TF_wen(b_wen), .o_TF_ren(b_ren), .o_LAST_STAGE(b_last),
    .o_l(b_l), .o_it_depth_cnt(b_dep), .o_ite_sw_cnt(b_ite), .o_ite_sw_cnt_ite3(b_ite3), .o_modulus(b_mod)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Done scoreboard: each accepted start pushes one entry; each done pulse pops one.
  always @(negedge clk) begin
    if (!rst && a_done) begin
      if (sb.size() == 0) begin
        check_eq($sformatf("unexpected_done@%0d", cyc), 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc >= 0) check_eq("done_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("done_ite3", a_ite3, e.ite3);
        check_eq("done_modulus", a_mod, e.mod);
      end
    end
  end

  // Unstalled schedule of DUT A: 21 cycles per stage = 2 seed + 16 read + 3 drain.
  task automatic expect_nominal(input int r);
    int s, p, e_l, e_dep, e_ite, e_ite3;
    logic e_wen, e_ren, e_busy, e_last;
    e_wen = 0; e_ren = 0; e_busy = 0; e_last = 0;
    e_l = 0; e_dep = 0; e_ite = 0; e_ite3 = 0; s = 0; p = 0;
    if (r >= 1 && r <= 63) begin
      s = (r - 1) / 21;
      p = (r - 1) % 21;
      e_busy = 1; e_l = s; e_last = (s == 2);
      if (p < 2) begin
        e_wen = 1; e_dep = p; e_ite3 = s * 4;
      end else if (p < 18) begin
        e_ren = 1; e_dep = (p - 2) % 4; e_ite = (p - 2) / 4; e_ite3 = s * 4 + e_ite;
      end else begin
        e_ite3 = s * 4 + 4;
      end
    end else if (r >= 64) begin
      e_busy = (r == 64); e_l = 2; e_last = 1; e_ite3 = 12;
    end
    check_eq($sformatf("wen@%0d", r), a_wen, e_wen);
    check_eq($sformatf("ren@%0d", r), a_ren, e_ren);
    check_eq($sformatf("busy@%0d", r), a_busy, e_busy);
    check_eq($sformatf("last@%0d", r), a_last, e_last);
    check_eq($sformatf("l@%0d", r), a_l, e_l);
    check_eq($sformatf("depth@%0d", r), a_dep, e_dep);
    check_eq($sformatf("ite@%0d", r), a_ite, e_ite);
    check_eq($sformatf("ite3@%0d", r), a_ite3, e_ite3);
    check_eq($sformatf("done@%0d", r), a_done, (r == 64));
    check_eq($sformatf("mod@%0d", r), a_mod, (r == 0) ? 64'h0 : 64'h3001);
  endtask

  initial begin
    int t0;
    int cnt_wen[3];
    int cnt_ren[3];
    int both;
    bit seen_done;
    rst = 1'b1;
    a_start = 0; a_dp = 1; a_mod_in = 0;
    b_start = 0; b_dp = 1; b_mod_in = 0;
    next_cycle();
    @(negedge clk);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_wen", a_wen, 0);
    check_eq("rst_ren", a_ren, 0);
    check_eq("rst_last", a_last, 0);
    check_eq("rst_l", a_l, 0);
    check_eq("rst_ite3", a_ite3, 0);
    check_eq("rst_mod", a_mod, 0);
    next_cycle();
    rst = 1'b0;

    // Nominal pass
    t0 = cyc;
    for (int r = 0; r <= 66; r++) begin
      a_start = (r == 0); a_mod_in = 64'h3001; a_dp = 1;
      if (r == 0) sb.push_back('{t0 + 64, 64'd12, 64'h3001});
      @(negedge clk);
      expect_nominal(r);
      next_cycle();
    end
    a_start = 0;

    // Stall dp_ready in cycles 5..9
    t0 = cyc;
    for (int r = 0; r <= 72; r++) begin
      a_start = (r == 0); a_dp = !(r >= 5 && r <= 9);
      if (r == 0) sb.push_back('{t0 + 69, 64'd12, 64'h3001});
      @(negedge clk);
      if (r == 4) begin
        check_eq("stall_pre_ren", a_ren, 1);
        check_eq("stall_pre_dep", a_dep, 1);
      end
      if (r >= 5 && r <= 9) begin
        check_eq($sformatf("stall_ren@%0d", r), a_ren, 0);
        check_eq($sformatf("stall_dep@%0d", r), a_dep, 2);
        check_eq($sformatf("stall_ite@%0d", r), a_ite, 0);
      end
      if (r == 10) begin
        check_eq("stall_post_ren", a_ren, 1);
        check_eq("stall_post_dep", a_dep, 2);
      end
      next_cycle();
    end
    a_dp = 1;

    // Start while busy and in DONE is ignored; start from IDLE restarts
    t0 = cyc;
    for (int r = 0; r <= 131; r++) begin
      a_start = (r == 0 || r == 10 || r == 64 || r == 65);
      a_mod_in = (r < 10) ? 64'h3001 : ((r < 65) ? 64'hBEEF : 64'h5555);
      if (r == 0) sb.push_back('{t0 + 64, 64'd12, 64'h3001});
      if (r == 65) sb.push_back('{t0 + 129, 64'd12, 64'h5555});
      @(negedge clk);
      if (r == 11) check_eq("restart_ignored_l", a_wen, 0);
      if (r == 65) check_eq("idle_busy@65", a_busy, 0);
      if (r == 66) begin
        check_eq("new_pass_ite3@66", a_ite3, 0);
        check_eq("new_pass_wen@66", a_wen, 1);
        check_eq("new_pass_l@66", a_l, 0);
        check_eq("new_pass_mod@66", a_mod, 64'h5555);
      end
      next_cycle();
    end
    a_start = 0;
    check_eq("sb_drained_t3", 64'(sb.size()), 0);

    // Asynchronous reset mid-pass
    t0 = cyc;
    for (int r = 0; r <= 99; r++) begin
      a_start = (r == 0 || r == 33);
      a_mod_in = 64'h3001;
      if (r == 0) sb.push_back('{t0 + 64, 64'd12, 64'h3001});
      if (r == 30) begin
        rst = 1'b1;
        sb.delete();
      end
      if (r == 32) rst = 1'b0;
      if (r == 33) sb.push_back('{t0 + 97, 64'd12, 64'h3001});
      @(negedge clk);
      if (r == 29) check_eq("pre_rst_l", a_l, 1);
      if (r == 30) begin
        check_eq("arst_busy", a_busy, 0);
        check_eq("arst_ren", a_ren, 0);
        check_eq("arst_wen", a_wen, 0);
        check_eq("arst_l", a_l, 0);
        check_eq("arst_dep", a_dep, 0);
        check_eq("arst_ite", a_ite, 0);
        check_eq("arst_ite3", a_ite3, 0);
        check_eq("arst_mod", a_mod, 0);
      end
      next_cycle();
    end
    a_start = 0;
    check_eq("sb_drained_t4", 64'(sb.size()), 0);

    // Minimal single-stage configuration
    for (int r = 0; r <= 5; r++) begin
      b_start = (r == 0); b_mod_in = 64'h77; b_dp = 1;
      @(negedge clk);
      if (r == 1) begin
        check_eq("b_last@1", b_last, 1);
        check_eq("b_wen@1", b_wen, 1);
        check_eq("b_ren@1", b_ren, 0);
        check_eq("b_mod@1", b_mod, 64'h77);
      end
      if (r == 2) begin
        check_eq("b_ren@2", b_ren, 1);
        check_eq("b_wen@2", b_wen, 0);
      end
      if (r == 3) check_eq("b_ren@3", b_ren, 0);
      check_eq($sformatf("b_done@%0d", r), b_done, (r == 4));
      if (r == 4) check_eq("b_ite3@4", b_ite3, 1);
      if (r == 5) check_eq("b_busy@5", b_busy, 0);
      next_cycle();
    end
    b_start = 0;

    // Random readiness over many transforms
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 3; i++) begin
        cnt_wen[i] = 0;
        cnt_ren[i] = 0;
      end
      both = 0;
      seen_done = 0;
      a_start = 1;
      a_mod_in = {32'h0, $urandom};
      a_dp = ($urandom_range(0, 1) == 1);
      sb.push_back('{-1, 64'd12, a_mod_in});
      for (int r = 0; r < 3000 && !seen_done; r++) begin
        @(negedge clk);
        if (a_wen && a_ren) both++;
        if (a_l < 3) begin
          if (a_wen) cnt_wen[a_l]++;
          if (a_ren) cnt_ren[a_l]++;
        end
        seen_done = a_done;
        next_cycle();
        a_start = 0;
        a_dp = ($urandom_range(0, 1) == 1);
      end
      check_eq($sformatf("rand_timeout_t%0d", k), seen_done, 1);
      check_eq($sformatf("rand_both_t%0d", k), 64'(both), 0);
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("rand_wen_t%0d_s%0d", k, i), 64'(cnt_wen[i]), 2);
        check_eq($sformatf("rand_ren_t%0d_s%0d", k, i), 64'(cnt_ren[i]), 16);
      end
    end
    a_dp = 1;
    next_cycle();
    check_eq("sb_drained_final", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
